pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the fetch stage. It holds the PC and advances it by a fixed step. It also handles stall, branch/jump redirect, call/return through an internal return-address stack (RAS), and overflow/underflow error flags. The PC is driven to the shared datapath bus through a tri-state read enable and is also available as an always-driven copy for the instruction-memory address.

---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/ras_stack.sv | 57 +++++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: reset default and next-PC select.
package pc_pkg;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_REDIRECT,
        SEL_RAS
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch front end (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic             ret;
    logic             r_en;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;
    logic             ras_underflow;

    modport master (
        output stall, redirect_valid, redirect_target, call, ret, r_en,
        input  pc, pc_plus, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, call, ret, r_en,
        output pc, pc_plus, ras_empty, ras_full, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           clr_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [WIDTH-1:0]               push_data_i,
    output logic [WIDTH-1:0]               top_data_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count_o,
    output logic                           empty_o,
    output logic                           full_o
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(RAS_DEPTH - 1);

    logic [PtrW-1:0]  top_q, top_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] mem_q [RAS_DEPTH];

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CntW'(RAS_DEPTH));
    assign count_o    = count_q;
    assign top_data_o = mem_q[top_q];

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (push_i) begin
            top_d = (top_q == LastPtr) ? '0 : top_q + 1'b1;
            if (!full_o) count_d = count_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            top_d   = (top_q == '0) ? LastPtr : top_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Storage is not cleared; count alone defines validity.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[top_d] <= push_data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with stall, redirect, call/return via RAS, and a tri-state bus copy.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEFAULT),
    parameter int unsigned      STEP      = 1,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clr,
    pc_sequencer_if.slave     ctrl,
    output wire [WIDTH-1:0]   pc_bus
);

    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    pc_sel_e          sel;
    logic             ras_push, ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic [CntW-1:0]  ras_count;
    logic             ras_empty, ras_full;

    assign pc_inc = pc_q + WIDTH'(STEP);

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk),
        .clr_i       (clr),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_data_o  (ras_top),
        .count_o     (ras_count),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    // Priority: redirect > stall > ret > increment.
    always_comb begin
        sel      = SEL_INC;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (ctrl.redirect_valid) begin
            sel      = SEL_REDIRECT;
            ras_push = ctrl.call;
            if (ctrl.call && (ras_count == CntW'(RAS_DEPTH))) ovf_d = 1'b1;
        end else if (ctrl.stall) begin
            sel = SEL_HOLD;
        end else if (ctrl.ret) begin
            if (!ras_empty) begin
                sel     = SEL_RAS;
                ras_pop = 1'b1;
            end else begin
                sel   = SEL_HOLD;
                unf_d = 1'b1;
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            SEL_HOLD:     pc_d = pc_q;
            SEL_INC:      pc_d = pc_inc;
            SEL_REDIRECT: pc_d = ctrl.redirect_target;
            SEL_RAS:      pc_d = ras_top;
            default:      pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ctrl.pc            = pc_q;
    assign ctrl.pc_plus       = pc_inc;
    assign ctrl.ras_empty     = ras_empty;
    assign ctrl.ras_full      = ras_full;
    assign ctrl.ras_overflow  = ovf_q;
    assign ctrl.ras_underflow = unf_q;

    assign pc_bus = ctrl.r_en ? pc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: a 16-bit depth-4 sequencer driven from a vector table, plus an 8-bit depth-3
// instance for wrap-around and mid-stack clear.
module tb_pc_sequencer;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr, clr8;
    int   errors = 0;
    int   checks = 0;

    pc_sequencer_if #(.WIDTH(W)) ifc ();
    pc_sequencer_if #(.WIDTH(8)) ifc8 ();

    wire  [W-1:0] pc_bus;
    wire  [7:0]   pc_bus8;
    logic         tb_drv;
    logic [W-1:0] tb_val;

    // Second driver on the shared bus: only resolves cleanly if the DUT has released it.
    assign pc_bus = tb_drv ? tb_val : {W{1'bz}};

    pc_sequencer #(
        .WIDTH     (W),
        .RESET_VEC (16'h0000),
        .STEP      (1),
        .RAS_DEPTH (4)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .ctrl   (ifc),
        .pc_bus (pc_bus)
    );

    pc_sequencer #(
        .WIDTH     (8),
        .RESET_VEC (8'h20),
        .STEP      (1),
        .RAS_DEPTH (3)
    ) dut8 (
        .clk    (clk),
        .clr    (clr8),
        .ctrl   (ifc8),
        .pc_bus (pc_bus8)
    );

    typedef struct {
        logic         clr;
        logic         rv;
        logic [W-1:0] tgt;
        logic         call;
        logic         ret;
        logic         stall;
        logic [W-1:0] pc;
        logic         empty;
        logic         full;
        logic         ovf;
        logic         unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic c, input logic rv, input logic [W-1:0] tgt,
                               input logic call, input logic ret, input logic stall,
                               input logic [W-1:0] pc, input logic e, input logic f,
                               input logic o, input logic u);
        vec_t r;
        r.clr = c; r.rv = rv; r.tgt = tgt; r.call = call; r.ret = ret; r.stall = stall;
        r.pc = pc; r.empty = e; r.full = f; r.ovf = o; r.unf = u;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; clr8 = 1'b1; tb_drv = 1'b0; tb_val = '0;
        ifc.stall = 0; ifc.redirect_valid = 0; ifc.redirect_target = '0;
        ifc.call = 0; ifc.ret = 0; ifc.r_en = 0;
        ifc8.stall = 0; ifc8.redirect_valid = 0; ifc8.redirect_target = '0;
        ifc8.call = 0; ifc8.ret = 0; ifc8.r_en = 0;

        //      clr rv tgt       call ret stall  pc      e  f  o  u
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0002, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0003, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0004, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0005, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 1, 16'h0005, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 1, 16'h0005, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0040, 0, 0, 1, 16'h0040, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0041, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0010, 0, 0, 0, 16'h0010, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0100, 1, 0, 0, 16'h0100, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0101, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0200, 1, 0, 0, 16'h0200, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0102, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0011, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0300, 1, 0, 0, 16'h0300, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0400, 1, 0, 0, 16'h0400, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0500, 1, 0, 0, 16'h0500, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0600, 1, 0, 0, 16'h0600, 0, 1, 0, 0));
        vecs.push_back(v(0, 1, 16'h0700, 1, 0, 0, 16'h0700, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0601, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0501, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0401, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0301, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0301, 1, 0, 1, 1));
        // clr beats a simultaneous redirect+call+ret
        vecs.push_back(v(1, 1, 16'hBEEF, 1, 1, 0, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0800, 1, 0, 0, 16'h0800, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0900, 1, 1, 0, 16'h0900, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 1, 16'h0900, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0801, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0001, 1, 0, 0, 0));

        // Reset state of the main instance
        tick();
        chk("rst_pc", 32'(ifc.pc), 32'h0);
        chk("rst_pc_plus", 32'(ifc.pc_plus), 32'h1);
        chk("rst_empty", 32'(ifc.ras_empty), 32'h1);
        chk("rst_full", 32'(ifc.ras_full), 32'h0);
        chk("rst_ovf", 32'(ifc.ras_overflow), 32'h0);
        chk("rst_unf", 32'(ifc.ras_underflow), 32'h0);
        clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            clr                 = vecs[i].clr;
            ifc.redirect_valid  = vecs[i].rv;
            ifc.redirect_target = vecs[i].tgt;
            ifc.call            = vecs[i].call;
            ifc.ret             = vecs[i].ret;
            ifc.stall           = vecs[i].stall;
            tick();
            chk($sformatf("v%0d_pc", i), 32'(ifc.pc), 32'(vecs[i].pc));
            chk($sformatf("v%0d_pc_plus", i), 32'(ifc.pc_plus), 32'(vecs[i].pc + 16'h1));
            chk($sformatf("v%0d_empty", i), 32'(ifc.ras_empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d_full", i), 32'(ifc.ras_full), 32'(vecs[i].full));
            chk($sformatf("v%0d_ovf", i), 32'(ifc.ras_overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_unf", i), 32'(ifc.ras_underflow), 32'(vecs[i].unf));
        end
        clr = 1'b0; ifc.redirect_valid = 0; ifc.call = 0; ifc.ret = 0; ifc.stall = 0;

        // Bus driver: copy of pc when enabled, fully released otherwise
        ifc.r_en = 1'b1;
        #1 chk("bus_en", 32'(pc_bus), 32'h0001);
        ifc.r_en = 1'b0; tb_drv = 1'b1; tb_val = 16'hA5A5;
        #1 chk("bus_release_a5", 32'(pc_bus), 32'hA5A5);
        tb_val = 16'h5A5A;
        #1 chk("bus_release_5a", 32'(pc_bus), 32'h5A5A);
        tb_drv = 1'b0;

        // 8-bit, depth-3 instance: reset vector, wrap, overflow, mid-stack clear
        tick();
        chk("w8_rst_pc", 32'(ifc8.pc), 32'h20);
        chk("w8_rst_plus", 32'(ifc8.pc_plus), 32'h21);
        chk("w8_rst_empty", 32'(ifc8.ras_empty), 32'h1);
        ifc8.r_en = 1'b1;
        #1 chk("w8_bus", 32'(pc_bus8), 32'h20);
        ifc8.r_en = 1'b0;
        clr8 = 1'b0;
        ifc8.redirect_valid = 1; ifc8.redirect_target = 8'hFE;
        tick();
        chk("w8_pc_fe", 32'(ifc8.pc), 32'hFE);
        ifc8.redirect_valid = 0;
        tick();
        chk("w8_pc_ff", 32'(ifc8.pc), 32'hFF);
        chk("w8_plus_wrap", 32'(ifc8.pc_plus), 32'h00);
        tick();
        chk("w8_pc_wrap", 32'(ifc8.pc), 32'h00);
        ifc8.redirect_valid = 1; ifc8.call = 1;
        ifc8.redirect_target = 8'h10; tick();
        ifc8.redirect_target = 8'h30; tick();
        ifc8.redirect_target = 8'h50; tick();
        chk("w8_full3", 32'(ifc8.ras_full), 32'h1);
        chk("w8_no_ovf3", 32'(ifc8.ras_overflow), 32'h0);
        ifc8.redirect_target = 8'h70; tick();
        chk("w8_pc_70", 32'(ifc8.pc), 32'h70);
        chk("w8_ovf", 32'(ifc8.ras_overflow), 32'h1);
        ifc8.redirect_valid = 0; ifc8.call = 0;
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        chk("w8_clr_pc", 32'(ifc8.pc), 32'h20);
        chk("w8_clr_empty", 32'(ifc8.ras_empty), 32'h1);
        chk("w8_clr_full", 32'(ifc8.ras_full), 32'h0);
        chk("w8_clr_ovf", 32'(ifc8.ras_overflow), 32'h0);
        chk("w8_clr_unf", 32'(ifc8.ras_underflow), 32'h0);
        ifc8.ret = 1'b1;
        tick();
        ifc8.ret = 1'b0;
        chk("w8_ret_empty_pc", 32'(ifc8.pc), 32'h20);
        chk("w8_ret_empty_unf", 32'(ifc8.ras_underflow), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
